// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and fetch state type for the instruction fetch unit
// Contents: ADDR_W, INSTR_W, RESET_PC, PC_LIMIT, INSTR_BYTES, LAST_WORD, fetch_state_t {RUN, FAULT}
package if_pkg;

    localparam int ADDR_W      = 64;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;
    localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(224);

    // Highest byte address at which a whole word still fits below PC_LIMIT.
    localparam logic [ADDR_W-1:0] LAST_WORD = PC_LIMIT - ADDR_W'(INSTR_BYTES);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch program counter with load, hold and increment
// Ports: clk, rst_n (async active-low), load / load_value (redirect), inc (advance by one word), pc (current PC)
module program_counter
    import if_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // Load wins over increment; with neither asserted the PC holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + ADDR_W'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - IF stage: PC, instruction memory address, IF/ID capture, fault FSM
// Ports: clk, rst_n (async active-low); imem_addr / imem_data (combinational memory);
//        stall, branch_taken, branch_target (pipeline control);
//        if_id_instr, if_id_pc, if_id_valid (IF/ID register); fault (sticky); fetch_count (captures, wraps)
module instruction_fetch_unit
    import if_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid,
    output logic               fault,
    output logic [31:0]        fetch_count
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic              pc_inc;
    logic              capture;
    logic              squash;
    logic              legal;

    program_counter u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pc_load),
        .load_value (branch_target),
        .inc        (pc_inc),
        .pc         (pc)
    );

    assign imem_addr = pc;
    assign fault     = (state_q == FAULT);

    // Checked against the current PC only; a branch target is validated once it becomes the PC.
    assign legal = (pc[1:0] == 2'b00) && (pc <= LAST_WORD);

    always_comb begin
        state_d = state_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        capture = 1'b0;
        squash  = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                    squash  = 1'b1;
                end else if (!stall) begin
                    if (legal) begin
                        capture = 1'b1;
                        pc_inc  = 1'b1;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                if_id_instr <= imem_data;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end else if (squash || (state_d == FAULT)) begin
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic        fault;
    logic [31:0] fetch_count;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } cap_t;

    cap_t       sb[$];
    cap_t       e;
    int         errors;
    int         checks;
    logic [7:0] mem [0:225];

    instruction_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .fault         (fault),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        if (a <= 64'd222)
            return {mem[int'(a)], mem[int'(a) + 1], mem[int'(a) + 2], mem[int'(a) + 3]};
        return 32'h0;
    endfunction

    assign imem_data = word_at(imem_addr);

    task automatic set_word(input int a, input logic [31:0] w);
        mem[a]     = w[31:24];
        mem[a + 1] = w[23:16];
        mem[a + 2] = w[15:8];
        mem[a + 3] = w[7:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_id_instr !== 32'h0 || if_id_pc !== 64'h0 || if_id_valid !== 1'b0 ||
            fault !== 1'b0 || fetch_count !== 32'h0 || imem_addr !== 64'h0) begin
            errors++;
            $display("FAIL reset_state got instr=%h pc=%0d valid=%b fault=%b count=%0d addr=%0d expected all zero",
                     if_id_instr, if_id_pc, if_id_valid, fault, fetch_count, imem_addr);
        end
        #1 rst_n = 1'b1;
        sb.push_back('{32'hF8428005, 64'd0});
        sb.push_back('{32'hF845000A, 64'd4});
        sb.push_back('{32'h8A0A00A1, 64'd8});
        for (int i = 0; i < 3; i++) begin
            step();
            e = sb.pop_front();
            checks++;
            if (if_id_valid !== 1'b1 || if_id_instr !== e.instr || if_id_pc !== e.pc) begin
                errors++;
                $display("FAIL reset_fetch%0d got instr=%h pc=%0d valid=%b expected instr=%h pc=%0d valid=1",
                         i, if_id_instr, if_id_pc, if_id_valid, e.instr, e.pc);
            end
        end
        checks++;
        if (fetch_count !== 32'd3 || imem_addr !== 64'd12) begin
            errors++;
            $display("FAIL reset_count got count=%0d addr=%0d expected count=3 addr=12", fetch_count, imem_addr);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        sb.push_back('{32'hF8428005, 64'd0});
        sb.push_back('{32'hF845000A, 64'd4});
        for (int i = 0; i < 2; i++) begin
            step();
            e = sb.pop_front();
            checks++;
            if (if_id_valid !== 1'b1 || if_id_instr !== e.instr || if_id_pc !== e.pc) begin
                errors++;
                $display("FAIL stall_prefetch%0d got instr=%h pc=%0d expected instr=%h pc=%0d",
                         i, if_id_instr, if_id_pc, e.instr, e.pc);
            end
        end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (if_id_instr !== 32'hF845000A || if_id_pc !== 64'd4 || imem_addr !== 64'd8 ||
                fetch_count !== 32'd2 || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d got instr=%h pc=%0d addr=%0d count=%0d valid=%b expected F845000A/4 addr=8 count=2 valid=1",
                         i, if_id_instr, if_id_pc, imem_addr, fetch_count, if_id_valid);
            end
        end
        stall = 1'b0;
        sb.push_back('{32'h8A0A00A1, 64'd8});
        step();
        e = sb.pop_front();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_instr !== e.instr || if_id_pc !== e.pc || fetch_count !== 32'd3) begin
            errors++;
            $display("FAIL stall_release got instr=%h pc=%0d count=%0d expected instr=%h pc=%0d count=3",
                     if_id_instr, if_id_pc, fetch_count, e.instr, e.pc);
        end
    endtask

    task automatic test_branch_over_stall();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 64'd24;
        step();
        checks++;
        if (if_id_valid !== 1'b0 || imem_addr !== 64'd24 || fetch_count !== 32'd3 ||
            if_id_instr !== 32'h8A0A00A1 || if_id_pc !== 64'd8) begin
            errors++;
            $display("FAIL branch_squash got valid=%b addr=%0d count=%0d instr=%h pc=%0d expected valid=0 addr=24 count=3 instr=8A0A00A1 pc=8",
                     if_id_valid, imem_addr, fetch_count, if_id_instr, if_id_pc);
        end
        stall = 1'b0; branch_taken = 1'b0;
        sb.push_back('{32'hF8008001, 64'd24});
        step();
        e = sb.pop_front();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_instr !== e.instr || if_id_pc !== e.pc || imem_addr !== 64'd28) begin
            errors++;
            $display("FAIL branch_target_fetch got instr=%h pc=%0d valid=%b addr=%0d expected instr=%h pc=%0d valid=1 addr=28",
                     if_id_instr, if_id_pc, if_id_valid, imem_addr, e.instr, e.pc);
        end
    endtask

    task automatic test_misaligned_fault();
        logic [31:0] cnt;
        cnt = fetch_count;
        branch_taken = 1'b1; branch_target = 64'd26;
        step();
        branch_taken = 1'b0;
        checks++;
        if (imem_addr !== 64'd26 || fault !== 1'b0 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_redirect got addr=%0d fault=%b valid=%b expected addr=26 fault=0 valid=0",
                     imem_addr, fault, if_id_valid);
        end
        step();
        checks++;
        if (fault !== 1'b1 || if_id_valid !== 1'b0 || imem_addr !== 64'd26) begin
            errors++;
            $display("FAIL misalign_fault got fault=%b valid=%b addr=%0d expected fault=1 valid=0 addr=26",
                     fault, if_id_valid, imem_addr);
        end
        branch_taken = 1'b1; branch_target = 64'd0;
        step();
        step();
        branch_taken = 1'b0;
        checks++;
        if (fault !== 1'b1 || if_id_valid !== 1'b0 || imem_addr !== 64'd26 || fetch_count !== cnt) begin
            errors++;
            $display("FAIL fault_sticky got fault=%b valid=%b addr=%0d count=%0d expected fault=1 valid=0 addr=26 count=%0d",
                     fault, if_id_valid, imem_addr, fetch_count, cnt);
        end
    endtask

    task automatic test_limit();
        apply_reset();
        branch_taken = 1'b1; branch_target = 64'd220;
        step();
        branch_taken = 1'b0;
        sb.push_back('{word_at(64'd220), 64'd220});
        step();
        e = sb.pop_front();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_instr !== e.instr || if_id_pc !== e.pc ||
            imem_addr !== 64'd224 || fault !== 1'b0 || fetch_count !== 32'd1) begin
            errors++;
            $display("FAIL limit_last_word got instr=%h pc=%0d valid=%b addr=%0d fault=%b count=%0d expected instr=%h pc=220 valid=1 addr=224 fault=0 count=1",
                     if_id_instr, if_id_pc, if_id_valid, imem_addr, fault, fetch_count, e.instr);
        end
        step();
        checks++;
        if (fault !== 1'b1 || if_id_valid !== 1'b0 || imem_addr !== 64'd224 ||
            if_id_pc !== 64'd220 || fetch_count !== 32'd1) begin
            errors++;
            $display("FAIL limit_fault got fault=%b valid=%b addr=%0d pc=%0d count=%0d expected fault=1 valid=0 addr=224 pc=220 count=1",
                     fault, if_id_valid, imem_addr, if_id_pc, fetch_count);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) step();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 64'd40;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (if_id_instr !== 32'h0 || if_id_pc !== 64'h0 || if_id_valid !== 1'b0 ||
            fault !== 1'b0 || fetch_count !== 32'h0 || imem_addr !== 64'h0) begin
            errors++;
            $display("FAIL async_reset got instr=%h pc=%0d valid=%b fault=%b count=%0d addr=%0d expected all zero",
                     if_id_instr, if_id_pc, if_id_valid, fault, fetch_count, imem_addr);
        end
        stall = 1'b0; branch_taken = 1'b0;
        #1 rst_n = 1'b1;
        sb.push_back('{32'hF8428005, 64'd0});
        step();
        e = sb.pop_front();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_instr !== e.instr || if_id_pc !== e.pc || fetch_count !== 32'd1) begin
            errors++;
            $display("FAIL async_reset_refetch got instr=%h pc=%0d valid=%b count=%0d expected instr=%h pc=%0d valid=1 count=1",
                     if_id_instr, if_id_pc, if_id_valid, fetch_count, e.instr, e.pc);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 226; i++) mem[i] = 8'((i * 37 + 5) & 8'hFF);
        set_word(0,  32'hF8428005);
        set_word(4,  32'hF845000A);
        set_word(8,  32'h8A0A00A1);
        set_word(24, 32'hF8008001);
        set_word(220, 32'hD65F03C0);
        test_reset();
        test_stall();
        test_branch_over_stall();
        test_misaligned_fault();
        test_limit();
        test_async_reset();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
